// File: rtl/sys_ctrl_burst.sv
// Byte-frame command controller: decodes RX frames into register-file and ALU
// accesses (single and burst) and streams response bytes into the TX FIFO.
module sys_ctrl_burst #(
  parameter int ADDR_W    = 4,
  parameter int ALU_W     = 16,
  parameter int FUNC_W    = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_valid,
  input  logic              fifo_full,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic              alu_en,
  output logic [FUNC_W-1:0] alu_func,
  output logic              clk_gate_en,
  output logic [7:0]        tx_data,
  output logic              tx_wr_inc,
  output logic              cmd_err
);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int NBYTES = ALU_W / 8;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUNC,
    RD_REQ, RD_WAIT, ALU_WAIT, SEND
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              alu_en_q, alu_en_d;
  logic [FUNC_W-1:0] alu_func_q, alu_func_d;
  logic              gate_q, gate_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        nbytes_q, nbytes_d;
  logic [ALU_W-1:0]  shift_q, shift_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              collecting, busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_func_q <= '0;
      gate_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      alu_func_q <= alu_func_d;
      gate_q     <= gate_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    alu_func_d = alu_func_q;
    gate_d     = gate_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    shift_d    = shift_q;
    tmo_d      = '0;
    tx_wr_inc  = 1'b0;
    tx_data    = shift_q[7:0];
    collecting = state_q inside {GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUNC};
    busy       = state_q inside {RD_REQ, RD_WAIT, ALU_WAIT, SEND};

    // Burst write: step the address once the previous write has been presented.
    if (wr_en_q && op_q == 8'hEE && state_q == GET_DATA)
      addr_d = addr_q + 1'b1;

    unique case (state_q)
      IDLE: if (rx_valid) begin
        op_d = rx_data;
        unique case (rx_data)
          8'hAA, 8'hBB, 8'hEE, 8'hFF: state_d = GET_ADDR;
          8'hCC:                      state_d = GET_OPA;
          8'hDD:                      state_d = GET_FUNC;
          default:                    err_d   = 1'b1;
        endcase
      end
      GET_ADDR: if (rx_valid) begin
        addr_d = rx_data[ADDR_W-1:0];
        cnt_d  = 8'd1;
        unique case (op_q)
          8'hAA:   state_d = GET_DATA;
          8'hBB:   state_d = RD_REQ;
          default: state_d = GET_CNT;
        endcase
      end
      GET_CNT: if (rx_valid) begin
        cnt_d = rx_data;
        if (rx_data == 8'd0) begin
          state_d = IDLE;
        end else if (int'(rx_data) > MAX_BURST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = (op_q == 8'hEE) ? GET_DATA : RD_REQ;
        end
      end
      GET_DATA: if (rx_valid) begin
        wr_en_d   = 1'b1;
        wr_data_d = rx_data;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = IDLE;
      end
      GET_OPA: if (rx_valid) begin
        addr_d    = '0;
        wr_data_d = rx_data;
        wr_en_d   = 1'b1;
        state_d   = GET_OPB;
      end
      GET_OPB: if (rx_valid) begin
        addr_d    = ADDR_W'(1);
        wr_data_d = rx_data;
        wr_en_d   = 1'b1;
        state_d   = GET_FUNC;
      end
      GET_FUNC: if (rx_valid) begin
        alu_func_d = rx_data[FUNC_W-1:0];
        alu_en_d   = 1'b1;
        gate_d     = 1'b1;
        state_d    = ALU_WAIT;
      end
      RD_REQ: begin
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (rd_valid) begin
        shift_d  = ALU_W'(rd_data);
        nbytes_d = 8'd1;
        state_d  = SEND;
      end
      ALU_WAIT: if (alu_valid) begin
        shift_d  = alu_out;
        nbytes_d = 8'(NBYTES);
        gate_d   = 1'b0;
        state_d  = SEND;
      end
      SEND: if (!fifo_full) begin
        tx_wr_inc = 1'b1;
        shift_d   = shift_q >> 8;
        nbytes_d  = nbytes_q - 8'd1;
        if (nbytes_q == 8'd1) begin
          if (op_q == 8'hFF && cnt_q > 8'd1) begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_q + 1'b1;
            state_d = RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte timer: only runs while a frame is partially received.
    if (collecting && !rx_valid) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
    if (busy && rx_valid) err_d = 1'b1;
  end

  assign addr        = addr_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign rd_en       = rd_en_q;
  assign alu_en      = alu_en_q;
  assign alu_func    = alu_func_q;
  assign clk_gate_en = gate_q;
  assign cmd_err     = err_q;
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: register-file/ALU responders, directed table,
// hand-written corner sequences and random frames against a frame-level model.
module tb_sys_ctrl_burst;
  localparam int ADDR_W = 4, ALU_W = 16, FUNC_W = 4, MAX_BURST = 16, TIMEOUT = 40;
  localparam int NB = ALU_W / 8;
  localparam int AW_MOD = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          len;
    logic [47:0] bytes;
    logic [15:0] alu;
    int          n_wr;
    logic [11:0] last_wr;
    int          n_tx;
    logic [7:0]  tx_first;
    logic [7:0]  tx_last;
    int          n_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic rd_valid = 1'b0;
  logic [ALU_W-1:0] alu_out = '0;
  logic alu_valid = 1'b0;
  logic fifo_full = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic wr_en, rd_en, alu_en, clk_gate_en, tx_wr_inc, cmd_err;
  logic [7:0] wr_data, tx_data;
  logic [FUNC_W-1:0] alu_func;

  sys_ctrl_burst #(.ADDR_W(ADDR_W), .ALU_W(ALU_W), .FUNC_W(FUNC_W),
                   .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .alu_out(alu_out), .alu_valid(alu_valid),
    .fifo_full(fifo_full), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .alu_en(alu_en), .alu_func(alu_func), .clk_gate_en(clk_gate_en),
    .tx_data(tx_data), .tx_wr_inc(tx_wr_inc), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]        mem [AW_MOD] = '{default: 8'h00};
  logic [7:0]        ref_mem [AW_MOD] = '{default: 8'h00};
  logic [11:0]       act_wr[$], exp_wr[$];
  logic [7:0]        act_tx[$], exp_tx[$];
  int                exp_err = 0, err_cycles = 0, err0 = 0;
  int                first_push_cyc = -1, last_rx_cyc = 0;
  int                alu_cnt = 0, alu_delay = 1;
  logic              prev_err = 1'b0, rd_seen = 1'b0;
  logic [ADDR_W-1:0] rd_addr_seen = '0;
  logic [ALU_W-1:0]  alu_val = '0;
  logic [FUNC_W-1:0] last_func = '0;
  logic              force_full = 1'b0, rand_full = 1'b0;
  vec_t              vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment: observe DUT strobes at negedge, answer reads/ALU and drive fifo_full after posedge.
  always begin
    @(negedge clk);
    if (rst) begin
      rd_seen = 1'b0; alu_cnt = 0; prev_err = 1'b0;
    end else begin
      if (wr_en) begin
        mem[addr] = wr_data;
        act_wr.push_back({addr, wr_data});
      end
      if (tx_wr_inc) begin
        check("push_while_full", 32'(fifo_full), 0);
        if (act_tx.size() == 0) first_push_cyc = cyc;
        act_tx.push_back(tx_data);
      end
      if (cmd_err) begin
        check("err_single_cycle", 32'(prev_err), 0);
        err_cycles++;
      end
      prev_err = cmd_err;
      if (alu_valid) check("gate_at_alu_valid", 32'(clk_gate_en), 1);
      rd_seen = rd_en;
      rd_addr_seen = addr;
      if (alu_en) begin
        alu_cnt = alu_delay;
        last_func = alu_func;
      end
    end
    @(posedge clk); #1;
    rd_valid = rd_seen;
    rd_data  = rd_seen ? mem[rd_addr_seen] : 8'h00;
    alu_valid = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin alu_valid = 1'b1; alu_out = alu_val; end
    end
    fifo_full = force_full | (rand_full & ($urandom_range(0, 3) == 0));
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1; last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bq_t f, input int maxgap);
    foreach (f[i]) send_byte(f[i], (i == f.size() - 1) ? 0 : $urandom_range(0, maxgap));
  endtask

  task automatic clear_obs();
    act_wr.delete(); act_tx.delete(); err0 = err_cycles; first_push_cyc = -1;
  endtask

  task automatic wait_done(input int ntx);
    int k = 0;
    while (act_tx.size() < ntx && k < 800) begin @(posedge clk); #1; k++; end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic wr_ref(input int a, input logic [7:0] d);
    ref_mem[a % AW_MOD] = d;
    exp_wr.push_back({ADDR_W'(a % AW_MOD), d});
  endtask

  // Frame-level reference: what each command must do to the register file and TX stream.
  task automatic model_frame(input bq_t f, input logic [ALU_W-1:0] av);
    int a, n;
    exp_wr.delete(); exp_tx.delete(); exp_err = 0;
    a = (f.size() > 1) ? int'(f[1]) : 0;
    n = (f.size() > 2) ? int'(f[2]) : 0;
    case (f[0])
      8'hAA: wr_ref(a, f[2]);
      8'hBB: exp_tx.push_back(ref_mem[a % AW_MOD]);
      8'hCC, 8'hDD: begin
        if (f[0] == 8'hCC) begin wr_ref(0, f[1]); wr_ref(1, f[2]); end
        for (int i = 0; i < NB; i++) exp_tx.push_back(8'(av >> (8 * i)));
      end
      8'hEE: if (n > MAX_BURST) exp_err = 1;
             else for (int i = 0; i < n; i++) wr_ref(a + i, f[3 + i]);
      8'hFF: if (n > MAX_BURST) exp_err = 1;
             else for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[(a + i) % AW_MOD]);
      default: exp_err = 1;
    endcase
  endtask

  task automatic cmp_obs(input string tag);
    logic [11:0] aw, ew;
    logic [7:0]  at, et;
    aw = '0; ew = '0; at = '0; et = '0;
    check({tag, "_err"}, 32'(err_cycles - err0), 32'(exp_err));
    check({tag, "_nwr"}, 32'(act_wr.size()), 32'(exp_wr.size()));
    check({tag, "_ntx"}, 32'(act_tx.size()), 32'(exp_tx.size()));
    for (int i = exp_wr.size() - 1; i >= 0; i--)
      if (i < act_wr.size() && act_wr[i] !== exp_wr[i]) begin aw = act_wr[i]; ew = exp_wr[i]; end
    for (int i = exp_tx.size() - 1; i >= 0; i--)
      if (i < act_tx.size() && act_tx[i] !== exp_tx[i]) begin at = act_tx[i]; et = exp_tx[i]; end
    check({tag, "_wrval"}, 32'(aw), 32'(ew));
    check({tag, "_txval"}, 32'(at), 32'(et));
  endtask

  task automatic run_frame(input bq_t f, input logic [ALU_W-1:0] av, input string tag, input int maxgap);
    clear_obs();
    alu_val = av;
    model_frame(f, av);
    send_frame(f, maxgap);
    wait_done(exp_tx.size());
    cmp_obs(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check(tag, {addr, wr_en, wr_data, rd_en, alu_en, alu_func, clk_gate_en,
                tx_data, tx_wr_inc, cmd_err}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t fr;
    vec[0] = '{3, 48'hAA053C000000, 16'h0000, 1, 12'h53C, 0, 8'h00, 8'h00, 0};
    vec[1] = '{2, 48'hBB0500000000, 16'h0000, 0, 12'h000, 1, 8'h3C, 8'h3C, 0};
    vec[2] = '{4, 48'hCC1234000000, 16'h0046, 2, 12'h134, 2, 8'h46, 8'h00, 0};
    vec[3] = '{6, 48'hEE0E03A1A2A3, 16'h0000, 3, 12'h0A3, 0, 8'h00, 8'h00, 0};
    vec[4] = '{2, 48'hBB0F00000000, 16'h0000, 0, 12'h000, 1, 8'hA2, 8'hA2, 0};
    vec[5] = '{1, 48'h550000000000, 16'h0000, 0, 12'h000, 0, 8'h00, 8'h00, 1};
    vec[6] = '{3, 48'hEE0011000000, 16'h0000, 0, 12'h000, 0, 8'h00, 8'h00, 1};
    vec[7] = '{3, 48'hFF0E00000000, 16'h0000, 0, 12'h000, 0, 8'h00, 8'h00, 0};
    vec[8] = '{2, 48'hDD0700000000, 16'hBEEF, 0, 12'h000, 2, 8'hEF, 8'hBE, 0};
    vec[9] = '{2, 48'hBB0000000000, 16'h0000, 0, 12'h000, 1, 8'hA3, 8'hA3, 0};

    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 10; i++) begin
      fr.delete();
      for (int j = 0; j < vec[i].len; j++) fr.push_back(vec[i].bytes[47 - 8 * j -: 8]);
      clear_obs();
      alu_val = vec[i].alu;
      model_frame(fr, vec[i].alu);
      send_frame(fr, 1);
      wait_done(vec[i].n_tx);
      check($sformatf("v%0d_err", i), 32'(err_cycles - err0), 32'(vec[i].n_err));
      check($sformatf("v%0d_nwr", i), 32'(act_wr.size()), 32'(vec[i].n_wr));
      check($sformatf("v%0d_ntx", i), 32'(act_tx.size()), 32'(vec[i].n_tx));
      if (vec[i].n_wr > 0 && act_wr.size() > 0)
        check($sformatf("v%0d_lastwr", i), 32'(act_wr[act_wr.size() - 1]), 32'(vec[i].last_wr));
      if (vec[i].n_tx > 0 && act_tx.size() > 0) begin
        check($sformatf("v%0d_tx_first", i), 32'(act_tx[0]), 32'(vec[i].tx_first));
        check($sformatf("v%0d_tx_last", i), 32'(act_tx[act_tx.size() - 1]), 32'(vec[i].tx_last));
      end
      if (fr[0] == 8'hCC) check($sformatf("v%0d_func", i), 32'(last_func), 32'(fr[3][FUNC_W-1:0]));
      if (fr[0] == 8'hDD) check($sformatf("v%0d_func", i), 32'(last_func), 32'(fr[1][FUNC_W-1:0]));
      if (fr[0] == 8'hCC || fr[0] == 8'hDD) check($sformatf("v%0d_gate_off", i), 32'(clk_gate_en), 0);
    end

    // Read latency: addr byte to first push with a 1-cycle register-file response.
    run_frame('{8'hAA, 8'h07, 8'h9E}, '0, "lat_wr", 0);
    run_frame('{8'hBB, 8'h07}, '0, "lat_rd", 0);
    check("rd_latency", 32'(first_push_cyc - last_rx_cyc), 4);

    // Burst read with the FIFO backing up during the second byte.
    clear_obs();
    fr = '{8'hFF, 8'h00, 8'h04};
    model_frame(fr, '0);
    send_frame(fr, 0);
    for (int k = 0; k < 100 && act_tx.size() < 1; k++) begin @(posedge clk); #1; end
    force_full = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("held_while_full", 32'(act_tx.size()), 1);
    force_full = 1'b0;
    wait_done(4);
    cmp_obs("burst_rd_full");

    // A byte arriving while the ALU is busy is dropped with an error; the ALU op completes.
    clear_obs();
    alu_delay = 5;
    alu_val = 16'h5A3C;
    model_frame('{8'hDD, 8'h03}, alu_val);
    exp_err = 1;
    send_byte(8'hDD, 0);
    send_byte(8'h03, 1);
    send_byte(8'h77, 0);
    wait_done(NB);
    cmp_obs("busy_rx");
    alu_delay = 1;

    // Longest legal inter-byte gap is accepted.
    clear_obs();
    model_frame('{8'hAA, 8'h06, 8'h5C}, '0);
    send_byte(8'hAA, 0);
    send_byte(8'h06, TIMEOUT - 1);
    send_byte(8'h5C, 0);
    wait_done(0);
    cmp_obs("gap_max");

    // Timeout: addr received, then silence.
    clear_obs();
    send_byte(8'hAA, 0);
    send_byte(8'h03, 0);
    repeat (TIMEOUT + 3) begin @(posedge clk); #1; end
    check("timeout_err", 32'(err_cycles - err0), 1);
    check("timeout_nwr", 32'(act_wr.size()), 0);
    run_frame('{8'hAA, 8'h03, 8'h77}, '0, "after_timeout", 1);

    // Reset between addr and data bytes abandons the frame.
    clear_obs();
    send_byte(8'hAA, 0);
    send_byte(8'h09, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midframe_reset_outputs");
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("midframe_reset_nwr", 32'(act_wr.size()), 0);
    run_frame('{8'hAA, 8'h09, 8'h5A}, '0, "after_reset", 1);

    // Random frames with random FIFO back-pressure and ALU latency.
    rand_full = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int sel, n;
      logic [7:0] badop [4];
      badop = '{8'h00, 8'h55, 8'h12, 8'hA9};
      fr.delete();
      sel = $urandom_range(0, 6);
      alu_delay = $urandom_range(1, 3);
      case (sel)
        0: fr = '{8'hAA, 8'($urandom), 8'($urandom)};
        1: fr = '{8'hBB, 8'($urandom)};
        2: fr = '{8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
        3: fr = '{8'hDD, 8'($urandom)};
        4: begin
          n = $urandom_range(0, MAX_BURST + 2);
          fr = '{8'hEE, 8'($urandom), 8'(n)};
          if (n <= MAX_BURST) for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
        end
        5: begin
          n = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
          fr = '{8'hFF, 8'($urandom), 8'(n)};
        end
        default: fr = '{badop[$urandom_range(0, 3)]};
      endcase
      run_frame(fr, ALU_W'($urandom), $sformatf("rnd%0d_op%0h", t, fr[0]), 3);
    end
    rand_full = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
